sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the single-port 8x8 sRAM.
//  Requester 0 is the instruction-fetch side and requester 1 is the load/store side.
//  Per request: latches the winner's op, drives en/rd/wt/add/din for exactly 1 cycle,
//  captures dout one cycle later, then returns data plus a done pulse to that requester.
//  All sRAM control is owned here; no other block drives the sRAM pins.
// PARAMETERS
//  ADDR_W  8  address width (sRAM decodes only add[2:0]; upper bits are passed through)
//  DATA_W  8  data width
// PORTS
//  clk       in   1       system clock; all logic updates on posedge
//  rst_n     in   1       synchronous reset, active-low
//  req0/req1 in   1       request; held high until gnt seen
//  we0/we1   in   1       1=write, 0=read; sampled with req
//  addr0/1   in   ADDR_W  access address; sampled with req
//  wdata0/1  in   DATA_W  write data; sampled with req
//  gnt0/gnt1 out  1       1-cycle pulse: op latched, inputs may change
//  done0/1   out  1       1-cycle pulse: op complete (rdata valid if read)
//  rdata0/1  out  DATA_W  read data; held until next read completes for that port
//  mem_en    out  1       to sRAM en
//  mem_rd    out  1       to sRAM rd
//  mem_wt    out  1       to sRAM wt
//  mem_add   out  ADDR_W  to sRAM add
//  mem_din   out  DATA_W  to sRAM din
//  mem_dout  in   DATA_W  from sRAM dout (registered in sRAM)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, last=1 (port 0 wins first), all outputs 0.
//  All outputs are registered; mem_rd and mem_wt are never both 1; mem_en=0 outside ISSUE.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: if no req, stay. If one req, that port wins. If both, the port != last wins.
//    On that edge: latch we/addr/wdata, set winner id, set last=winner, gnt_winner=1,
//    set mem_en=1, mem_rd=~we, mem_wt=we, and drive mem_add/mem_din; go to ISSUE.
//  ISSUE (1 cycle): sRAM performs the op at the closing edge. On that edge: clear mem_*
//    (mem_add and mem_din hold their values), clear gnt, go to WAIT.
//  WAIT (1 cycle): mem_dout is valid. On that edge: if read, rdata_winner<=mem_dout;
//    done_winner=1; go to IDLE. Writes leave rdata unchanged.
//  Timing: req seen at edge E0 -> gnt high E0..E1 -> done high E2..E3.
//    A new op can be latched at edge E3; throughput is 1 op per 3 cycles.
//  The loser's req stays pending and is served in the next IDLE, so there is no starvation.
//  A req that is still high after its own done is treated as a new request.
//  Requester must drop req in the cycle gnt is high; if it does not, it is re-arbitrated.
//  Reset mid-operation: FSM is abandoned and no done is issued.
//    If rst_n is sampled low at the edge closing ISSUE, the sRAM still sees en=1 at that
//    edge, so the write/read completes in memory; this is accepted behaviour.
// TESTING
//  1 Reset, then req0 write addr=3 data=0xA5 -> gnt0 at E0, mem_wt=1 for 1 cycle, done0 at E2
//  2 After test 1, req1 read addr=3 -> mem_rd=1 for 1 cycle, done1 at E2, rdata1=0xA5; rdata0 unchanged
//  3 req0 and req1 both high and held after reset -> grants alternate 0,1,0,1; each done 3 cycles apart
//  4 req0 held continuously, req1 pulsed once -> req1 is served within 1 arbitration (<=6 cycles)
//  5 rst_n low during WAIT of a read -> no done, outputs 0 next cycle; next req0 is granted first
//  6 Assertion over all tests: never mem_rd&mem_wt; mem_en high exactly 1 cycle per gnt

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the sRAM arbiter.
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds it
// until gntN is seen. gntN is a 1-cycle pulse meaning the op is latched and the
// inputs may change; the requester drops reqN in that same cycle, otherwise it is
// re-arbitrated as a new request. doneN is a 1-cycle pulse meaning the op has
// completed; rdataN is valid with done for reads and holds until the next read
// on that port completes.
//   master: requester side (drives req/we/addr/wdata)
//   slave : arbiter side   (drives gnt/done/rdata)
interface sram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata0, rdata1
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port 8x8 sRAM.
// Port 0 is instruction fetch, port 1 is load/store. Each op runs
// IDLE -> ISSUE -> WAIT -> IDLE: the sRAM strobes are driven for exactly the
// ISSUE cycle, the registered sRAM output is captured at the end of WAIT.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : requester handshake (sram_arbiter_if.slave)
//   o_mem_en/rd/wt : sRAM strobes, high only during ISSUE, rd/wt exclusive
//   o_mem_add/din  : sRAM address / write data, held after ISSUE
//   i_mem_dout     : registered sRAM read data
//   o_state        : FSM state for debug/checkers
module sram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sram_arbiter_if.slave     bus,
  output logic              o_mem_en,
  output logic              o_mem_rd,
  output logic              o_mem_wt,
  output logic [ADDR_W-1:0] o_mem_add,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic [1:0]        o_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]        r_state;
  logic              r_last;   // last winner; the other port wins a tie
  logic              r_win;    // port of the op in flight
  logic              r_we;     // op in flight is a write
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_mem_en;
  logic              r_mem_rd;
  logic              r_mem_wt;
  logic [ADDR_W-1:0] r_mem_add;
  logic [DATA_W-1:0] r_mem_din;

  logic              w_any_req;
  logic              w_pick;
  logic              w_pick_we;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_wdata;

  // Single requester wins outright; on a tie the port that did not win last.
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
    w_pick    = 1'b0;
    if (bus.req0 && bus.req1) w_pick = ~r_last;
    else if (bus.req1)        w_pick = 1'b1;
    w_pick_we    = w_pick ? bus.we1    : bus.we0;
    w_pick_addr  = w_pick ? bus.addr1  : bus.addr0;
    w_pick_wdata = w_pick ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_we      <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_mem_en  <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_wt  <= 1'b0;
      r_mem_add <= '0;
      r_mem_din <= '0;
    end else begin
      // gnt and done are single-cycle pulses.
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_win     <= w_pick;
            r_last    <= w_pick;
            r_we      <= w_pick_we;
            r_gnt0    <= ~w_pick;
            r_gnt1    <= w_pick;
            r_mem_en  <= 1'b1;
            r_mem_rd  <= ~w_pick_we;
            r_mem_wt  <= w_pick_we;
            r_mem_add <= w_pick_addr;
            r_mem_din <= w_pick_wdata;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // sRAM acts on this closing edge; address/data are left as they were.
          r_mem_en <= 1'b0;
          r_mem_rd <= 1'b0;
          r_mem_wt <= 1'b0;
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!r_we) begin
            if (r_win) r_rdata1 <= i_mem_dout;
            else       r_rdata0 <= i_mem_dout;
          end
          r_done0 <= ~r_win;
          r_done1 <= r_win;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0   = r_gnt0;
  assign bus.gnt1   = r_gnt1;
  assign bus.done0  = r_done0;
  assign bus.done1  = r_done1;
  assign bus.rdata0 = r_rdata0;
  assign bus.rdata1 = r_rdata1;
  assign o_mem_en   = r_mem_en;
  assign o_mem_rd   = r_mem_rd;
  assign o_mem_wt   = r_mem_wt;
  assign o_mem_add  = r_mem_add;
  assign o_mem_din  = r_mem_din;
  assign o_state    = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 8x8 sRAM (registered dout).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       mem_en;
  logic       mem_rd;
  logic       mem_wt;
  logic [7:0] mem_add;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sram[8];

  sram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  sram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_mem_en   (mem_en),
    .o_mem_rd   (mem_rd),
    .o_mem_wt   (mem_wt),
    .o_mem_add  (mem_add),
    .o_mem_din  (mem_din),
    .i_mem_dout (mem_dout),
    .o_state    (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sRAM model: acts on the edge closing ISSUE, dout registered
  initial begin
    for (int i = 0; i < 8; i++) sram[i] = 8'h00;
    mem_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wt) sram[mem_add[2:0]] <= mem_din;
      if (mem_rd) mem_dout <= sram[mem_add[2:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe rules checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_on) begin
      check("rd_wt_exclusive", {31'd0, mem_rd & mem_wt}, 32'd0);
      check("en_matches_gnt", {31'd0, mem_en}, {31'd0, bus.gnt0 | bus.gnt1});
    end
  end

  // driver tasks
  task automatic clear_reqs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int port, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  // per-cycle check of grant/done pulses against bit patterns indexed by cycle
  task automatic check_pat(input string tag, input int k, input logic [11:0] g0,
                           input logic [11:0] g1, input logic [11:0] d0,
                           input logic [11:0] d1);
    check($sformatf("%s_gnt0_k%0d", tag, k), {31'd0, bus.gnt0}, {31'd0, g0[k]});
    check($sformatf("%s_gnt1_k%0d", tag, k), {31'd0, bus.gnt1}, {31'd0, g1[k]});
    check($sformatf("%s_done0_k%0d", tag, k), {31'd0, bus.done0}, {31'd0, d0[k]});
    check($sformatf("%s_done1_k%0d", tag, k), {31'd0, bus.done1}, {31'd0, d1[k]});
  endtask

  initial begin
    logic [11:0] g0, g1, d0, d1;
    int lat;
    int raise_k;
    bit seen;

    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    apply_reset();
    mon_on = 1;

    // reset state
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    check("rst_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    check("rst_rdata", {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    check("rst_mem", {13'd0, mem_en, mem_rd, mem_wt, mem_add, mem_din}, 32'd0);

    // 1: port 0 writes 0xA5 to address 3
    set_req(0, 1'b1, 8'h03, 8'hA5);
    @(negedge clk);
    check("t1_gnt0", {31'd0, bus.gnt0}, 32'd1);
    check("t1_state_issue", {30'd0, state}, 32'd1);
    check("t1_strobes", {29'd0, mem_en, mem_rd, mem_wt}, 32'b101);
    check("t1_add", {24'd0, mem_add}, 32'h03);
    check("t1_din", {24'd0, mem_din}, 32'hA5);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("t1_gnt0_drop", {31'd0, bus.gnt0}, 32'd0);
    check("t1_strobes_off", {29'd0, mem_en, mem_rd, mem_wt}, 32'd0);
    check("t1_add_held", {24'd0, mem_add}, 32'h03);
    check("t1_state_wait", {30'd0, state}, 32'd2);
    check("t1_no_early_done", {31'd0, bus.done0}, 32'd0);
    @(negedge clk);
    check("t1_done0", {30'd0, bus.done1, bus.done0}, 32'b01);
    check("t1_state_idle", {30'd0, state}, 32'd0);
    check("t1_sram_written", {24'd0, sram[3]}, 32'hA5);
    @(negedge clk);
    check("t1_done0_pulse", {31'd0, bus.done0}, 32'd0);

    // 2: port 1 reads address 3
    set_req(1, 1'b0, 8'h03, 8'h00);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    check("t2_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'b10);
    check("t2_strobes", {29'd0, mem_en, mem_rd, mem_wt}, 32'b110);
    check("t2_add", {24'd0, mem_add}, 32'h03);
    bus.req1 = 1'b0;
    @(negedge clk);
    check("t2_strobes_off", {29'd0, mem_en, mem_rd, mem_wt}, 32'd0);
    @(negedge clk);
    check("t2_done1", {30'd0, bus.done1, bus.done0}, 32'b10);
    check("t2_rdata1", {24'd0, bus.rdata1}, {24'd0, exp_q.pop_front()});
    check("t2_rdata0_kept", {24'd0, bus.rdata0}, 32'h00);

    // 3: both held after reset -> grants 0,1,0,1 three cycles apart
    apply_reset();
    check("t3_rdata_cleared", {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    set_req(0, 1'b0, 8'h03, 8'h00);
    set_req(1, 1'b0, 8'h03, 8'h00);
    g0 = 12'h041; g1 = 12'h208; d0 = 12'h104; d1 = 12'h820;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_pat("t3", k, g0, g1, d0, d1);
    end
    clear_reqs();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    check("t3_rdata0", {24'd0, bus.rdata0}, {24'd0, exp_q.pop_front()});
    check("t3_rdata1", {24'd0, bus.rdata1}, {24'd0, exp_q.pop_front()});

    // 4: port 0 held, port 1 pulsed once -> port 1 served at next arbitration
    apply_reset();
    set_req(0, 1'b0, 8'h03, 8'h00);
    g0 = 12'h209; g1 = 12'h040; d0 = 12'h824; d1 = 12'h100;
    lat = 99;
    raise_k = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_pat("t4", k, g0, g1, d0, d1);
      if (bus.req1 && bus.gnt1) begin
        lat = k - raise_k;
        bus.req1 = 1'b0;
      end
      if (k == 3) begin
        set_req(1, 1'b0, 8'h03, 8'h00);
        raise_k = k;
      end
      if (k == 9) bus.req0 = 1'b0;
    end
    check("t4_req1_latency", lat, 32'd3);
    check("t4_within_6", {31'd0, lat <= 6}, 32'd1);
    check("t4_rdata0", {24'd0, bus.rdata0}, 32'hA5);

    // 5: reset during WAIT of a read -> no done, outputs cleared, port 0 first
    set_req(0, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    check("t5_gnt0", {31'd0, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("t5_in_wait", {30'd0, state}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_no_done", {30'd0, bus.done1, bus.done0}, 32'd0);
    check("t5_state", {30'd0, state}, 32'd0);
    check("t5_rdata_zero", {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    check("t5_mem_zero", {13'd0, mem_en, mem_rd, mem_wt, mem_add, mem_din}, 32'd0);
    rst_n = 1'b1;
    set_req(0, 1'b0, 8'h03, 8'h00);
    set_req(1, 1'b0, 8'h03, 8'h00);
    @(negedge clk);
    check("t5_first_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
    bus.req0 = 1'b0;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (bus.gnt1) seen = 1;
    end
    check("t5_gnt1_bounded", {31'd0, seen}, 32'd1);
    clear_reqs();
    repeat (4) @(negedge clk);
    check("t5_idle_end", {30'd0, state}, 32'd0);

    mon_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
